crc8_stream: RTL
================

CRC8_STREAM -- requirements
Module: crc8_stream

Interface
REQ-001 Parameter INIT, default 8'h00: remainder preload at the start of every frame.
REQ-002 Parameter XOROUT, default 8'h00: value XORed into the final remainder before it is presented.
REQ-003 Parameter LEN_W, default 16: width of the frame byte counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts a byte this cycle.
REQ-008 in_data  input  8  frame byte, processed MSB first.
REQ-009 in_last  input  1  marks the final byte of a frame.
REQ-010 out_valid  output  1  result registers hold a completed frame result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 out_crc  output  8  final remainder XOR XOROUT.
REQ-013 out_zero  output  1  raw final remainder (before XOROUT) equals 8'h00; check mode for frames with appended CRC.
REQ-014 out_len  output  LEN_W  bytes accepted in the frame, saturating at all-ones.

Function
REQ-015 The block SHALL use CRC-8 with poly 0x07, left shift, no input or output reflection.
REQ-016 The per-byte update SHALL be rem_next = F(rem XOR in_data), where F is 8 shift/conditional-XOR-0x07 steps (F(0x01)=0x07, F(0x80)=0x89).
REQ-017 The block SHALL implement states IDLE, ACCUM and HOLD, using a 2-bit state register.
REQ-018 An input transfer SHALL occur on a cycle where in_valid and in_ready are both 1.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-020 In IDLE, a transfer SHALL compute from INIT (rem = INIT and len = 0 implied) and go to ACCUM; if in_last is set, it SHALL go to HOLD instead.
REQ-021 In ACCUM, each transfer SHALL update rem and len.
REQ-022 In ACCUM, a transfer with in_last=1 SHALL load out_crc/out_zero/out_len from the updated values and go to HOLD.
REQ-023 out_valid SHALL be 1 exactly while in HOLD, with a result latency of 1 cycle after the in_last transfer edge.
REQ-024 In HOLD, out_crc/out_zero/out_len SHALL stay stable until out_valid and out_ready are both 1.
REQ-025 On that handshake, the block SHALL go to IDLE, and in_ready SHALL rise the following cycle (no same-cycle pass-through).
REQ-026 in_valid=0 in ACCUM SHALL leave all state unchanged, so a frame may stall indefinitely.
REQ-027 out_len SHALL count the in_last byte, so a single-byte frame gives out_len=1.
REQ-028 out_len SHALL hold at 2^LEN_W-1 once reached, without wrapping to 0, while the CRC keeps updating.
REQ-029 out_crc, out_zero and out_len SHALL keep their last values after the handshake until the next frame completes.
REQ-030 A zero-length frame is not possible; every frame SHALL contain at least one byte.

Reset
REQ-031 While rst_n=0, the block SHALL be in state IDLE with rem=INIT, len=0, in_ready=0, out_valid=0, out_crc=8'h00, out_zero=0 and out_len=0.
REQ-032 Assertion SHALL take effect immediately, with no clock needed.
REQ-033 Deassertion SHALL be sampled synchronously, and in_ready SHALL become 1 on the first clock edge after rst_n rises.
REQ-034 Reset mid-frame or in HOLD SHALL discard the partial or pending result; no out_valid pulse follows.

Verification
REQ-035 Bytes "123456789" (0x31..0x39) with in_last on 0x39, out_ready=1 -> out_crc=0xF4, out_zero=0, out_len=9, out_valid high for 1 cycle.
REQ-036 Single byte 0x80 with in_last -> out_crc=0x89, out_len=1, out_valid asserted on the next edge.
REQ-037 Bytes 0x31..0x39 then 0xF4 (last) -> out_zero=1, out_crc=0x00; with XOROUT=8'h55 -> out_crc=0x55, out_zero=1.
REQ-038 Hold out_ready=0 for 5 cycles after a completed frame -> in_ready=0 and outputs stable throughout; a second frame is accepted only after the handshake.
REQ-039 Pull rst_n low mid-frame after 4 bytes, then send byte 0x01 with last -> out_crc=0x07, out_len=1.
REQ-040 With LEN_W=3, send 10 bytes -> out_len=7, and out_crc matches the full 10-byte CRC.

Source files
------------

// File: rtl/crc8_stream.sv
// crc8_stream: streaming CRC-8 (poly 0x07, MSB first, no reflection) over
// byte frames. Bytes arrive on a valid/ready input; the per-frame result
// (CRC, zero-remainder check flag, saturating byte count) is held on a
// valid/ready output until the consumer takes it.
module crc8_stream #(
  parameter logic [7:0] INIT   = 8'h00,
  parameter logic [7:0] XOROUT = 8'h00,
  parameter int         LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_crc_o,
  output logic             out_zero_o,
  output logic [LEN_W-1:0] out_len_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Eight shift/conditional-XOR steps of the 0x07 polynomial.
  function automatic logic [7:0] crc8_step8(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < 8; i++) begin
      if (r[7]) begin
        r = {r[6:0], 1'b0} ^ 8'h07;
      end else begin
        r = {r[6:0], 1'b0};
      end
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_crc_q, out_crc_d;
  logic             out_zero_q, out_zero_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;

  logic             xfer_s;
  logic [7:0]       base_rem_s;
  logic [LEN_W-1:0] base_len_s;
  logic [7:0]       upd_rem_s;
  logic [LEN_W-1:0] upd_len_s;

  assign xfer_s = in_valid_i & in_ready_q;

  // Per-byte datapath: a frame starts from INIT/0 in IDLE, else from the running state.
  always_comb begin
    base_rem_s = rem_q;
    base_len_s = len_q;
    if (state_q == IDLE) begin
      base_rem_s = INIT;
      base_len_s = '0;
    end else begin
      base_rem_s = rem_q;
      base_len_s = len_q;
    end
    upd_rem_s = crc8_step8(base_rem_s ^ in_data_i);
    if (base_len_s == LEN_MAX) begin
      upd_len_s = base_len_s;
    end else begin
      upd_len_s = base_len_s + LEN_ONE;
    end
  end

  // Next-state and result-load logic; result registers only change on an in_last transfer.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    len_d      = len_q;
    out_crc_d  = out_crc_q;
    out_zero_d = out_zero_q;
    out_len_d  = out_len_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer_s) begin
          rem_d = upd_rem_s;
          len_d = upd_len_s;
          if (in_last_i) begin
            state_d    = HOLD;
            out_crc_d  = upd_rem_s ^ XOROUT;
            out_zero_d = (upd_rem_s == 8'h00);
            out_len_d  = upd_len_s;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered copies of the next state, so in_ready
    // rises one cycle after the output handshake and after reset release.
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  // State, datapath and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= INIT;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_crc_q   <= 8'h00;
      out_zero_q  <= 1'b0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_crc_q   <= out_crc_d;
      out_zero_q  <= out_zero_d;
      out_len_q   <= out_len_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_crc_o   = out_crc_q;
  assign out_zero_o  = out_zero_q;
  assign out_len_o   = out_len_q;

endmodule
